aes_round_arbiter: RTL and testbench

- Shares one combinational single-round AES core (data_in, key, enc_dec -> data_out) between two requesters: port 0 is the CPU AES-instruction FSM, port 1 is a memory-side crypto engine.
- Accepts a 128-bit key/data job per port over valid/ready, arbitrates round-robin, and drives the core operands from registers.
- Samples the core result after a fixed settle delay and returns it to the issuing port over valid/ready.
- Sits between the CPU/engine FSMs and the aes_core instance.

---
 rtl/aes_round_arbiter.sv | 173 +++++++++++++++++
 tb/tb_aes_round_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_arbiter.sv
// aes_round_arbiter: shares one single-round AES core between two requesters.
// Jobs are accepted over valid/ready and arbitrated round-robin. The core
// operands are held in registers for CORE_LAT cycles, then the core result is
// returned to the port that issued the job.
// Optional build macro AES_ARB_FIXED_PRIO_EN: when both ports request at once,
// port 0 always wins.
module aes_round_arbiter #(
    parameter int unsigned CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_dec,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_data,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_dec,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_data,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    output logic         core_dec,
    input  logic [127:0] core_data_out,
    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           last_grant_q, last_grant_d;
    logic           grant_id_q, grant_id_d;
    logic [127:0]   core_data_in_q, core_data_in_d;
    logic [127:0]   core_key_q, core_key_d;
    logic           core_dec_q, core_dec_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [127:0]   rsp0_data_q, rsp0_data_d;
    logic [127:0]   rsp1_data_q, rsp1_data_d;

    logic           sel_valid;
    logic           sel_port;
    logic           rsp_handshake;

    // Pick the port that would be granted if the arbiter were idle this cycle.
    always_comb begin
        sel_valid = req0_valid | req1_valid;
        sel_port  = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef AES_ARB_FIXED_PRIO_EN
            sel_port = 1'b0;
`else
            sel_port = ~last_grant_q;
`endif
        end else begin
            sel_port = req1_valid;
        end
    end

    // Next-state logic, combinational ready outputs and operand/result capture.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        core_data_in_d = core_data_in_q;
        core_key_d     = core_key_q;
        core_dec_d     = core_dec_q;
        rsp0_valid_d   = rsp0_valid_q;
        rsp1_valid_d   = rsp1_valid_q;
        rsp0_data_d    = rsp0_data_q;
        rsp1_data_d    = rsp1_data_q;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        rsp_handshake  = grant_id_q ? (rsp1_valid_q && rsp1_ready)
                                    : (rsp0_valid_q && rsp0_ready);

        unique case (state_q)
            IDLE: begin
                req0_ready = sel_valid && !sel_port;
                req1_ready = sel_valid && sel_port;
                if (sel_valid) begin
                    core_data_in_d = sel_port ? req1_data : req0_data;
                    core_key_d     = sel_port ? req1_key  : req0_key;
                    core_dec_d     = sel_port ? req1_dec  : req0_dec;
                    grant_id_d     = sel_port;
                    last_grant_d   = sel_port;
                    cnt_d          = 4'(CORE_LAT - 1);
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 4'd0) begin
                    if (grant_id_q) begin
                        rsp1_data_d  = core_data_out;
                        rsp1_valid_d = 1'b1;
                    end else begin
                        rsp0_data_d  = core_data_out;
                        rsp0_valid_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_handshake) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    rsp0_data_d  = '0;
                    rsp1_data_d  = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            last_grant_q   <= 1'b1;
            grant_id_q     <= 1'b0;
            core_data_in_q <= '0;
            core_key_q     <= '0;
            core_dec_q     <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            grant_id_q     <= grant_id_d;
            core_data_in_q <= core_data_in_d;
            core_key_q     <= core_key_d;
            core_dec_q     <= core_dec_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp0_data_q    <= rsp0_data_d;
            rsp1_data_q    <= rsp1_data_d;
        end
    end

    assign core_data_in = core_data_in_q;
    assign core_key     = core_key_q;
    assign core_dec     = core_dec_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_arbiter.sv
// Directed bench for aes_round_arbiter: one instance with CORE_LAT = 1 and one
// with CORE_LAT = 4, each driving a stub core computing data ^ key ^ {dec}.
module tb_aes_round_arbiter;

    logic         clk;
    logic         reset_n;

    logic         req0_valid, req0_ready, req0_dec;
    logic [127:0] req0_key, req0_data;
    logic         rsp0_valid, rsp0_ready;
    logic [127:0] rsp0_data;
    logic         req1_valid, req1_ready, req1_dec;
    logic [127:0] req1_key, req1_data;
    logic         rsp1_valid, rsp1_ready;
    logic [127:0] rsp1_data;
    logic [127:0] core_data_in, core_key, core_data_out;
    logic         core_dec, busy, grant_id;

    logic         a_req0_valid, a_req0_ready, a_req0_dec;
    logic [127:0] a_req0_key, a_req0_data;
    logic         a_rsp0_valid, a_rsp0_ready;
    logic [127:0] a_rsp0_data;
    logic         a_req1_valid, a_req1_ready, a_req1_dec;
    logic [127:0] a_req1_key, a_req1_data;
    logic         a_rsp1_valid, a_rsp1_ready;
    logic [127:0] a_rsp1_data;
    logic [127:0] a_core_data_in, a_core_key, a_core_data_out;
    logic         a_core_dec, a_busy, a_grant_id;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] DATA_A = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] EXP_A  = 128'hF0E0D0C0B0A090807060504030201000;
    localparam logic [127:0] KEY_B  = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;
    localparam logic [127:0] DATA_B = 128'h12345678123456781234567812345678;
    localparam logic [127:0] EXP_B  = 128'h1234A9871234A9871234A9871234A987;
    localparam logic [127:0] KEY_C  = {16{8'hA5}};
    localparam logic [127:0] DATA_C = {16{8'h3C}};
    localparam logic [127:0] EXP_C  = {16{8'h99}};

    assign core_data_out   = core_data_in ^ core_key ^ {128{core_dec}};
    assign a_core_data_out = a_core_data_in ^ a_core_key ^ {128{a_core_dec}};

    aes_round_arbiter #(.CORE_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dec(req0_dec),
        .req0_key(req0_key), .req0_data(req0_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dec(req1_dec),
        .req1_key(req1_key), .req1_data(req1_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .core_data_in(core_data_in), .core_key(core_key), .core_dec(core_dec),
        .core_data_out(core_data_out), .busy(busy), .grant_id(grant_id)
    );

    aes_round_arbiter #(.CORE_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_dec(a_req0_dec),
        .req0_key(a_req0_key), .req0_data(a_req0_data),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready), .rsp0_data(a_rsp0_data),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_dec(a_req1_dec),
        .req1_key(a_req1_key), .req1_data(a_req1_data),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready), .rsp1_data(a_rsp1_data),
        .core_data_in(a_core_data_in), .core_key(a_core_key), .core_dec(a_core_dec),
        .core_data_out(a_core_data_out), .busy(a_busy), .grant_id(a_grant_id)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request port of the CORE_LAT = 1 instance.
    task automatic applyStimulus(input bit port, input logic valid, input logic dec,
                                 input logic [127:0] key, input logic [127:0] data);
        if (port) begin
            req1_valid = valid; req1_dec = dec; req1_key = key; req1_data = data;
        end else begin
            req0_valid = valid; req0_dec = dec; req0_key = key; req0_data = data;
        end
    endtask

    // One comparison: counts it, and on a mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed scenarios, sampled on the falling edge.
    initial begin
        bit exp_port [4];
`ifdef AES_ARB_FIXED_PRIO_EN
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        a_req0_valid = 1'b0; a_req0_dec = 1'b0; a_req0_key = '0; a_req0_data = '0;
        a_req1_valid = 1'b0; a_req1_dec = 1'b0; a_req1_key = '0; a_req1_data = '0;
        a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;

        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rsp0_valid", rsp0_valid, 0);
        checkOutput("reset_core_key", core_key, 0);
        checkOutput("reset_grant_id", grant_id, 0);
        @(negedge clk) reset_n = 1'b1;

        // Single port 0 encrypt job.
        $display("[TB] single port 0 job");
        applyStimulus(1'b0, 1'b1, 1'b0, KEY_A, DATA_A);
        rsp0_ready = 1'b1;
        #1 checkOutput("s1_req0_ready", req0_ready, 1);
        checkOutput("s1_req1_ready", req1_ready, 0);
        @(posedge clk); @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        #1 checkOutput("s1_ready_drop", req0_ready, 0);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_core_key", core_key, KEY_A);
        checkOutput("s1_early_valid", rsp0_valid, 0);
        @(posedge clk); @(negedge clk);
        checkOutput("s1_rsp0_valid", rsp0_valid, 1);
        checkOutput("s1_rsp0_data", rsp0_data, EXP_A);
        checkOutput("s1_rsp1_valid", rsp1_valid, 0);
        @(posedge clk); @(negedge clk);
        checkOutput("s1_valid_drop", rsp0_valid, 0);
        checkOutput("s1_idle", busy, 0);

        // Both ports request continuously from reset.
        $display("[TB] dual request arbitration");
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 128'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 128'h2);
        rsp1_ready = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 checkOutput("rr_req0_ready", req0_ready, exp_port[j] == 1'b0);
            checkOutput("rr_req1_ready", req1_ready, exp_port[j] == 1'b1);
            @(posedge clk); @(negedge clk);
            checkOutput("rr_grant_id", grant_id, exp_port[j]);
            @(posedge clk); @(negedge clk);
            checkOutput("rr_rsp_valid", exp_port[j] ? rsp1_valid : rsp0_valid, 1);
            checkOutput("rr_other_valid", exp_port[j] ? rsp0_valid : rsp1_valid, 0);
            checkOutput("rr_rsp_data", exp_port[j] ? rsp1_data : rsp0_data,
                        exp_port[j] ? 128'h2 : 128'h1);
            @(posedge clk); @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        #1 checkOutput("rr_drop_req1_ready", req1_ready, 1);
        checkOutput("rr_drop_req0_ready", req0_ready, 0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkOutput("rr_drop_rsp1_data", rsp1_data, 128'h2);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); @(negedge clk);

        // Port 1 decrypt job with a stalled consumer.
        $display("[TB] port 1 backpressure");
        rsp1_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, KEY_B, DATA_B);
        #1 checkOutput("bp_req1_ready", req1_ready, 1);
        @(posedge clk); @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, KEY_A, DATA_A);
        #1 checkOutput("bp_run_req0_ready", req0_ready, 0);
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_rsp1_valid", rsp1_valid, 1);
            checkOutput("bp_rsp1_data", rsp1_data, EXP_B);
            checkOutput("bp_busy", busy, 1);
            checkOutput("bp_req0_ready", req0_ready, 0);
            @(posedge clk); @(negedge clk);
        end
        rsp1_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("bp_after_busy", busy, 0);
        checkOutput("bp_after_valid", rsp1_valid, 0);
        checkOutput("bp_after_req0_ready", req0_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        // CORE_LAT = 4: inputs change after accept.
        $display("[TB] CORE_LAT 4 latency");
        a_req0_valid = 1'b1; a_req0_key = KEY_C; a_req0_data = DATA_C;
        #1 checkOutput("l4_req0_ready", a_req0_ready, 1);
        @(posedge clk); @(negedge clk);
        a_req0_valid = 1'b0; a_req0_key = KEY_A; a_req0_data = DATA_A; a_req0_dec = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 checkOutput("l4_run_valid", a_rsp0_valid, 0);
            checkOutput("l4_core_data_in", a_core_data_in, DATA_C);
            checkOutput("l4_core_key", a_core_key, KEY_C);
            @(posedge clk); @(negedge clk);
        end
        checkOutput("l4_rsp0_valid", a_rsp0_valid, 1);
        checkOutput("l4_rsp0_data", a_rsp0_data, EXP_C);
        @(posedge clk); @(negedge clk);
        checkOutput("l4_idle", a_busy, 0);

        // Reset pulse aborts a job in RUN.
        $display("[TB] reset during RUN");
        a_req0_valid = 1'b1; a_req0_dec = 1'b0; a_req0_key = KEY_C; a_req0_data = DATA_C;
        @(posedge clk); @(negedge clk);
        a_req0_valid = 1'b0;
        @(posedge clk); #2;
        checkOutput("ab_busy_before", a_busy, 1);
        reset_n = 1'b0;
        #1 checkOutput("ab_busy", a_busy, 0);
        checkOutput("ab_core_key", a_core_key, 0);
        checkOutput("ab_core_data_in", a_core_data_in, 0);
        checkOutput("ab_rsp0_valid", a_rsp0_valid, 0);
        @(negedge clk) reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("ab_no_rsp", a_rsp0_valid, 0);
        end
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1 checkOutput("ab_tie_req0_ready", a_req0_ready, 1);
        checkOutput("ab_tie_req1_ready", a_req1_ready, 0);
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
